// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU control path.
package cpu_pkg;

    localparam int OPCODE_WIDTH = 4;
    localparam int ALU_OP_WIDTH = 3;

    typedef enum logic [3:0] {
        OP_HLT  = 4'h0,
        OP_STO  = 4'h1,
        OP_LD   = 4'h2,
        OP_LDI  = 4'h3,
        OP_ADD  = 4'h4,
        OP_ADDI = 4'h5,
        OP_SUB  = 4'h6,
        OP_SUBI = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_NOT  = 4'hB,
        OP_BEQ  = 4'hC,
        OP_BNE  = 4'hD,
        OP_BLT  = 4'hE,
        OP_JMP  = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOT = 3'd5
    } alu_op_t;

    typedef enum logic [1:0] {
        ACC_ALU = 2'd0,
        ACC_IMM = 2'd1,
        ACC_MDR = 2'd2
    } acc_src_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_WAIT,
        S_EXECUTE,
        S_STORE,
        S_BRANCH,
        S_HALT
    } ctrl_state_t;

    function automatic alu_op_t alu_op_for(opcode_t op);
        case (op)
            OP_SUB, OP_SUBI: return ALU_SUB;
            OP_AND:          return ALU_AND;
            OP_OR:           return ALU_OR;
            OP_XOR:          return ALU_XOR;
            OP_NOT:          return ALU_NOT;
            default:         return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: IR/status/memory inputs and all datapath strobes.
interface control_unit_if #(
    parameter int OPCODE_WIDTH = cpu_pkg::OPCODE_WIDTH,
    parameter int ALU_OP_WIDTH = cpu_pkg::ALU_OP_WIDTH
);

    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    status_Z;
    logic                    status_N;
    logic                    mem_ready;

    logic                    ir_wr;
    logic                    pc_wr;
    logic                    pc_src;
    logic                    dmem_rd;
    logic                    dmem_wr;
    logic                    mdr_wr;
    logic                    acc_wr;
    logic [1:0]              acc_src;
    logic                    alu_b_src;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic                    status_wr;
    logic                    halted;
    logic                    mem_error;

    modport master (
        input  opcode, status_Z, status_N, mem_ready,
        output ir_wr, pc_wr, pc_src, dmem_rd, dmem_wr, mdr_wr, acc_wr,
               acc_src, alu_b_src, alu_op, status_wr, halted, mem_error
    );

    modport slave (
        output opcode, status_Z, status_N, mem_ready,
        input  ir_wr, pc_wr, pc_src, dmem_rd, dmem_wr, mdr_wr, acc_wr,
               acc_src, alu_b_src, alu_op, status_wr, halted, mem_error
    );

endinterface

// File: rtl/control_unit_branch_cond.sv
// Branch resolution: decides whether a branch opcode loads the PC given the Z/N flags.
module branch_cond
    import cpu_pkg::*;
(
    input  opcode_t opcode,
    input  logic    status_Z,
    input  logic    status_N,
    output logic    take
);

    always_comb begin
        take = 1'b0;
        case (opcode)
            OP_BEQ:  take = status_Z;
            OP_BNE:  take = !status_Z;
            OP_BLT:  take = status_N;
            OP_JMP:  take = 1'b1;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM of the accumulator CPU: sequences fetch/decode/memory/execute/branch
// and drives every datapath write enable from the current state.
module control_unit #(
    parameter int OPCODE_WIDTH = 4,
    parameter int ALU_OP_WIDTH = 3,
    parameter int MEM_TIMEOUT  = 15
) (
    input logic            clock,
    input logic            control_reset,
    control_unit_if.master bus
);
    import cpu_pkg::*;

    // One spare bit keeps the counter legal when the timeout is disabled.
    localparam int            CW    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW:0]   LIMIT = (CW + 1)'(MEM_TIMEOUT);

    ctrl_state_t   state;
    logic [CW-1:0] wait_cnt;
    logic          mem_error_q;
    opcode_t       op;
    logic          take;
    logic [CW:0]   wait_next;
    logic          timed_out;

    assign op        = opcode_t'(bus.opcode[OPCODE_WIDTH-1 -: 4]);
    assign wait_next = {1'b0, wait_cnt} + (CW + 1)'(1);
    // A ready in the limit cycle completes normally, so it masks the timeout.
    assign timed_out = (MEM_TIMEOUT != 0) && !bus.mem_ready && (wait_next == LIMIT);

    branch_cond u_branch_cond (
        .opcode   (op),
        .status_Z (bus.status_Z),
        .status_N (bus.status_N),
        .take     (take)
    );

    always_ff @(posedge clock) begin
        if (control_reset) begin
            state       <= S_FETCH;
            wait_cnt    <= '0;
            mem_error_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    wait_cnt <= '0;
                    case (op)
                        OP_HLT:                                   state <= S_HALT;
                        OP_STO:                                   state <= S_STORE;
                        OP_LDI, OP_ADDI, OP_SUBI, OP_NOT:         state <= S_EXECUTE;
                        OP_BEQ, OP_BNE, OP_BLT, OP_JMP:           state <= S_BRANCH;
                        default:                                  state <= S_MEM_WAIT;
                    endcase
                end
                S_MEM_WAIT, S_STORE: begin
                    if (bus.mem_ready) begin
                        state <= (state == S_MEM_WAIT) ? S_EXECUTE : S_FETCH;
                    end else if (timed_out) begin
                        state       <= S_HALT;
                        mem_error_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_next[CW-1:0];
                    end
                end
                S_EXECUTE: state <= S_FETCH;
                S_BRANCH:  state <= S_FETCH;
                S_HALT:    state <= S_HALT;
                default:   state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        bus.ir_wr     = 1'b0;
        bus.pc_wr     = 1'b0;
        bus.pc_src    = 1'b0;
        bus.dmem_rd   = 1'b0;
        bus.dmem_wr   = 1'b0;
        bus.mdr_wr    = 1'b0;
        bus.acc_wr    = 1'b0;
        bus.acc_src   = ACC_ALU;
        bus.alu_b_src = 1'b0;
        bus.alu_op    = ALU_OP_WIDTH'(ALU_ADD);
        bus.status_wr = 1'b0;
        bus.halted    = 1'b0;
        bus.mem_error = 1'b0;
        if (!control_reset) begin
            case (state)
                S_FETCH: begin
                    bus.ir_wr = 1'b1;
                    bus.pc_wr = 1'b1;
                end
                S_MEM_WAIT: begin
                    bus.dmem_rd = 1'b1;
                    bus.mdr_wr  = bus.mem_ready;
                end
                S_EXECUTE: begin
                    bus.acc_wr    = 1'b1;
                    bus.status_wr = 1'b1;
                    case (op)
                        OP_LD:  bus.acc_src = ACC_MDR;
                        OP_LDI: bus.acc_src = ACC_IMM;
                        default: begin
                            bus.acc_src   = ACC_ALU;
                            bus.alu_op    = ALU_OP_WIDTH'(alu_op_for(op));
                            bus.alu_b_src = (op == OP_ADDI) || (op == OP_SUBI);
                        end
                    endcase
                end
                S_STORE: bus.dmem_wr = 1'b1;
                S_BRANCH: begin
                    bus.pc_src = 1'b1;
                    bus.pc_wr  = take;
                end
                S_HALT: begin
                    bus.halted    = 1'b1;
                    bus.mem_error = mem_error_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected strobe sequences from an ISA-level model.
module tb_control_unit;

    typedef struct packed {
        logic       ir_wr;
        logic       pc_wr;
        logic       pc_src;
        logic       dmem_rd;
        logic       dmem_wr;
        logic       mdr_wr;
        logic       acc_wr;
        logic [1:0] acc_src;
        logic       alu_b_src;
        logic [2:0] alu_op;
        logic       status_wr;
        logic       halted;
        logic       mem_error;
    } outs_t;

    localparam int TIMEOUT = 15;

    logic clock = 1'b0;
    logic control_reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    control_unit_if #(.OPCODE_WIDTH(4), .ALU_OP_WIDTH(3)) bus ();

    control_unit #(.OPCODE_WIDTH(4), .ALU_OP_WIDTH(3), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clock         (clock),
        .control_reset (control_reset),
        .bus           (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    function automatic outs_t sample_outs();
        outs_t o;
        o.ir_wr     = bus.ir_wr;
        o.pc_wr     = bus.pc_wr;
        o.pc_src    = bus.pc_src;
        o.dmem_rd   = bus.dmem_rd;
        o.dmem_wr   = bus.dmem_wr;
        o.mdr_wr    = bus.mdr_wr;
        o.acc_wr    = bus.acc_wr;
        o.acc_src   = bus.acc_src;
        o.alu_b_src = bus.alu_b_src;
        o.alu_op    = bus.alu_op;
        o.status_wr = bus.status_wr;
        o.halted    = bus.halted;
        o.mem_error = bus.mem_error;
        return o;
    endfunction

    function automatic outs_t fetch_exp();
        outs_t o = '0;
        o.ir_wr = 1'b1;
        o.pc_wr = 1'b1;
        return o;
    endfunction

    // ISA-level meaning of the execute cycle for each opcode.
    function automatic outs_t exec_exp(input logic [3:0] op);
        outs_t o = '0;
        o.acc_wr    = 1'b1;
        o.status_wr = 1'b1;
        case (op)
            4'h2: o.acc_src = 2'd2;
            4'h3: o.acc_src = 2'd1;
            4'h4, 4'h5: o.alu_op = 3'd0;
            4'h6, 4'h7: o.alu_op = 3'd1;
            4'h8: o.alu_op = 3'd2;
            4'h9: o.alu_op = 3'd3;
            4'hA: o.alu_op = 3'd4;
            4'hB: o.alu_op = 3'd5;
            default: ;
        endcase
        o.alu_b_src = (op == 4'h5) || (op == 4'h7);
        return o;
    endfunction

    // Run one instruction from FETCH; w = wait cycles before mem_ready, negative = never ready.
    task automatic run_instr(input string name, input logic [3:0] op, input logic z, input logic n,
                             input int w);
        outs_t exp_q[$];
        bit    rdy_q[$];
        outs_t e;
        outs_t g;
        bit    is_load;
        is_load = (op == 4'h2) || (op == 4'h4) || (op == 4'h6) || (op >= 4'h8 && op <= 4'hA);

        exp_q.push_back(fetch_exp());
        rdy_q.push_back(1'($urandom));
        exp_q.push_back('0);
        rdy_q.push_back(1'($urandom));

        if (op == 4'h0) begin
            e = '0;
            e.halted = 1'b1;
            exp_q.push_back(e);
            rdy_q.push_back(1'($urandom));
        end else if (op == 4'h3 || op == 4'h5 || op == 4'h7 || op == 4'hB) begin
            exp_q.push_back(exec_exp(op));
            rdy_q.push_back(1'($urandom));
        end else if (op >= 4'hC) begin
            e = '0;
            e.pc_src = 1'b1;
            case (op)
                4'hC:    e.pc_wr = z;
                4'hD:    e.pc_wr = !z;
                4'hE:    e.pc_wr = n;
                default: e.pc_wr = 1'b1;
            endcase
            exp_q.push_back(e);
            rdy_q.push_back(1'($urandom));
        end else begin
            for (int k = 0; k < TIMEOUT; k++) begin
                e = '0;
                e.dmem_rd = is_load;
                e.dmem_wr = !is_load;
                if (w >= 0 && k == w) begin
                    e.mdr_wr = is_load;
                    exp_q.push_back(e);
                    rdy_q.push_back(1'b1);
                    if (is_load) begin
                        exp_q.push_back(exec_exp(op));
                        rdy_q.push_back(1'($urandom));
                    end
                    break;
                end
                exp_q.push_back(e);
                rdy_q.push_back(1'b0);
                if (k + 1 == TIMEOUT) begin
                    e = '0;
                    e.halted    = 1'b1;
                    e.mem_error = 1'b1;
                    exp_q.push_back(e);
                    rdy_q.push_back(1'($urandom));
                end
            end
        end

        for (int i = 0; i < exp_q.size(); i++) begin
            bus.opcode    = op;
            bus.status_Z  = z;
            bus.status_N  = n;
            bus.mem_ready = rdy_q[i];
            #1;
            g = sample_outs();
            checks++;
            if (g !== exp_q[i]) begin
                errors++;
                $display("FAIL %s op=%h cycle %0d: got %h expected %h", name, op, i, g, exp_q[i]);
            end
            if (i != exp_q.size() - 1 || exp_q[i].halted !== 1'b1) begin
                @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        outs_t g;
        control_reset = 1'b1;
        repeat (2) begin
            bus.mem_ready = 1'($urandom);
            bus.opcode    = 4'($urandom);
            #1;
            g = sample_outs();
            checks++;
            if (g !== outs_t'(0)) begin
                errors++;
                $display("FAIL reset_outputs: got %h expected %h", g, outs_t'(0));
            end
            @(posedge clock);
            #1;
        end
        control_reset = 1'b0;

        // Walk into EXECUTE of an ADDI, then reset mid-instruction.
        bus.opcode = 4'h5;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        #1;
        checks++;
        if (bus.acc_wr !== 1'b1) begin
            errors++;
            $display("FAIL reset_reach_execute: got acc_wr=%b expected 1", bus.acc_wr);
        end
        control_reset = 1'b1;
        repeat (2) begin
            #1;
            g = sample_outs();
            checks++;
            if (g !== outs_t'(0)) begin
                errors++;
                $display("FAIL reset_mid_op: got %h expected %h", g, outs_t'(0));
            end
            @(posedge clock);
            #1;
        end
        control_reset = 1'b0;
        #1;
        g = sample_outs();
        checks++;
        if (g !== fetch_exp()) begin
            errors++;
            $display("FAIL reset_to_fetch: got %h expected %h", g, fetch_exp());
        end
    endtask

    // Check the sticky halted state for 20 cycles, then reset back to FETCH.
    task automatic test_halt_hold(input string name, input logic err);
        outs_t e;
        outs_t g;
        e = '0;
        e.halted    = 1'b1;
        e.mem_error = err;
        for (int i = 0; i < 20; i++) begin
            bus.mem_ready = 1'($urandom);
            bus.opcode    = 4'($urandom);
            bus.status_Z  = 1'($urandom);
            bus.status_N  = 1'($urandom);
            #1;
            g = sample_outs();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s hold cycle %0d: got %h expected %h", name, i, g, e);
            end
            @(posedge clock);
            #1;
        end
        control_reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        control_reset = 1'b0;
        #1;
        g = sample_outs();
        checks++;
        if (g !== fetch_exp()) begin
            errors++;
            $display("FAIL %s release: got %h expected %h", name, g, fetch_exp());
        end
    endtask

    task automatic test_immediate();
        run_instr("addi", 4'h5, 1'b0, 1'b0, 0);
        run_instr("ldi", 4'h3, 1'b1, 1'b0, 0);
        run_instr("subi", 4'h7, 1'b0, 1'b1, 0);
        run_instr("not", 4'hB, 1'b0, 1'b0, 0);
    endtask

    task automatic test_memory();
        run_instr("ld_w2", 4'h2, 1'b0, 1'b0, 2);
        run_instr("add_w0", 4'h4, 1'b0, 1'b0, 0);
        run_instr("xor_w14", 4'hA, 1'b0, 1'b0, TIMEOUT - 1);
        run_instr("sto_w1", 4'h1, 1'b0, 1'b0, 1);
        run_instr("sto_w14", 4'h1, 1'b0, 1'b0, TIMEOUT - 1);
    endtask

    task automatic test_branches();
        run_instr("beq_z1", 4'hC, 1'b1, 1'b0, 0);
        run_instr("beq_z0", 4'hC, 1'b0, 1'b1, 0);
        run_instr("bne_z0", 4'hD, 1'b0, 1'b0, 0);
        run_instr("bne_z1", 4'hD, 1'b1, 1'b0, 0);
        run_instr("blt_n1", 4'hE, 1'b0, 1'b1, 0);
        run_instr("blt_n0", 4'hE, 1'b1, 1'b0, 0);
        run_instr("jmp", 4'hF, 1'b0, 1'b0, 0);
    endtask

    task automatic test_sto_timeout();
        run_instr("sto_timeout", 4'h1, 1'b0, 1'b0, -1);
        test_halt_hold("sto_timeout", 1'b1);
        run_instr("ld_timeout", 4'h2, 1'b0, 1'b0, -1);
        test_halt_hold("ld_timeout", 1'b1);
    endtask

    task automatic test_halt();
        run_instr("hlt", 4'h0, 1'b0, 1'b0, 0);
        test_halt_hold("hlt", 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_instr("random", 4'($urandom_range(1, 15)), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 4)));
        end
    endtask

    initial begin
        bus.opcode    = '0;
        bus.status_Z  = 1'b0;
        bus.status_N  = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clock);
        #1;
        test_reset();
        test_immediate();
        test_memory();
        test_branches();
        test_sto_timeout();
        test_halt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
